// File: rtl/ctrl_sequencer.sv
// Opcode queue feeding a 7-bit control decoder, one opcode at a time,
// with a per-opcode wait latency between issue and completion.
module ctrl_sequencer #(
  parameter int DEPTH = 4,
  parameter int LAT_W = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [6:0]               in_op,
  input  logic [LAT_W-1:0]         in_lat,
  output logic [6:0]               dec_op,
  output logic                     dec_issue,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 7 + LAT_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     wr_q, wr_d;
  logic [PW-1:0]     rd_q, rd_d;
  logic [CW-1:0]     count_q, count_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  logic [6:0]        op_q, op_d;
  logic [EW-1:0]     mem_q [DEPTH];
  logic [EW-1:0]     head;
  logic              push;
  logic              pop;

  // Full is judged on registered occupancy, so a pop never frees a slot early.
  assign in_ready = (count_q != CW'(DEPTH)) & ~flush;
  assign push     = in_valid & in_ready;
  assign pop      = (state_q == S_IDLE) & (count_q != '0) & ~flush;
  assign head     = mem_q[rd_q];

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    if (flush) begin
      state_d = S_IDLE;
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
      cnt_d   = '0;
    end else begin
      if (push) wr_d = wr_q + PW'(1);
      if (pop)  rd_d = rd_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      unique case (state_q)
        S_IDLE: begin
          if (pop) begin
            state_d = S_ISSUE;
            op_d    = head[EW-1:LAT_W];
            cnt_d   = head[LAT_W-1:0];
          end
        end
        S_ISSUE: state_d = S_WAIT;
        S_WAIT: begin
          if (cnt_q == '0) state_d = S_IDLE;
          else             cnt_d   = cnt_q - LAT_W'(1);
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_q] <= {in_op, in_lat};
  end

  assign dec_op    = op_q;
  assign dec_issue = (state_q == S_ISSUE);
  assign busy      = (state_q == S_ISSUE) | (state_q == S_WAIT);
  assign done      = (state_q == S_WAIT) & (cnt_q == '0);
  assign count     = count_q;

endmodule
